wisc_trace_tx: RTL

- Synthesizable retire-event transmitter in the WISC CPU's debug path.
- Samples the same write-back-stage commit signals and cache req/hit pulses that the simulation trace logger consumes.
- Buffers one event entry per active cycle in a FIFO, then serializes the entry into REG/LOAD/STORE/HALT records over a valid/ready port.
- Maintains frozen-at-halt performance counters, readable through a select mux.

---
 rtl/wisc_trace_pkg.sv | 40 ++++
 rtl/trace_evt_fifo.sv | 51 +++++
 rtl/wisc_trace_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wisc_trace_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wisc_trace_pkg: shared record, stat-select, FSM and event-entry definitions.
// Rev 1.0
// ---------------------------------------------------------------------------
package wisc_trace_pkg;

  localparam logic [1:0] REC_REG   = 2'd0;
  localparam logic [1:0] REC_LOAD  = 2'd1;
  localparam logic [1:0] REC_STORE = 2'd2;
  localparam logic [1:0] REC_HALT  = 2'd3;

  localparam logic [2:0] STAT_CYCLES = 3'd0;
  localparam logic [2:0] STAT_INST   = 3'd1;
  localparam logic [2:0] STAT_IREQ   = 3'd2;
  localparam logic [2:0] STAT_IHIT   = 3'd3;
  localparam logic [2:0] STAT_DREQ   = 3'd4;
  localparam logic [2:0] STAT_DHIT   = 3'd5;
  localparam logic [2:0] STAT_DROPS  = 3'd6;
  localparam int         NUM_STATS   = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMIT  = 2'd1;
  localparam logic [1:0] S_HALTR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Flag order inside an entry is also the record emission order.
  typedef struct packed {
    logic rg;
    logic ld;
    logic st;
  } evt_flags_t;

  // Entry layout: {flags, WriteRegister, WriteData, MemAddress, MemDataIn, MemDataOut}
  function automatic int entry_width(input int aw, input int rw);
    return 3 + rw + 4 * aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_evt_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_evt_fifo: synchronous FIFO, simultaneous push/pop, push ignored when full.
// Rev 1.0
// ---------------------------------------------------------------------------
module trace_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/wisc_trace_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wisc_trace_tx: capture write-back retire events, serialize REG/LOAD/STORE/HALT.
// Rev 1.0
// ---------------------------------------------------------------------------
module wisc_trace_tx
  import wisc_trace_pkg::*;
#(
  parameter int ARCH_WIDTH = 16,
  parameter int REG_WIDTH  = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Halt,
  input  logic                  RegWrite,
  input  logic [REG_WIDTH-1:0]  WriteRegister,
  input  logic [ARCH_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ARCH_WIDTH-1:0] MemAddress,
  input  logic [ARCH_WIDTH-1:0] MemDataIn,
  input  logic [ARCH_WIDTH-1:0] MemDataOut,
  input  logic                  icache_req,
  input  logic                  icache_hit,
  input  logic                  dcache_req,
  input  logic                  dcache_hit,
  input  logic                  rec_ready,
  output logic                  rec_valid,
  output logic [1:0]            rec_type,
  output logic [ARCH_WIDTH-1:0] rec_addr,
  output logic [ARCH_WIDTH-1:0] rec_data,
  input  logic [2:0]            stat_sel,
  output logic [CNT_WIDTH-1:0]  stat_value,
  output logic                  overflow,
  output logic                  done
);

  localparam int EW = entry_width(ARCH_WIDTH, REG_WIDTH);

  logic [2:0]            since_q;
  logic                  halt_q;
  logic                  overflow_q;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_STATS];
  logic [NUM_STATS-1:0]  stat_inc;

  logic [1:0]            state_q, state_d;
  logic [2:0]            flags_q, flags_d;
  logic [2:0]            sel_mask;
  logic [REG_WIDTH-1:0]  cur_wreg_q;
  logic [ARCH_WIDTH-1:0] cur_wdata_q, cur_addr_q, cur_sdata_q, cur_ldata_q;

  logic                  reg_f, capture, want_push, drop;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]         push_entry, pop_entry;
  evt_flags_t            pop_flags;
  logic [REG_WIDTH-1:0]  pop_wreg;
  logic [ARCH_WIDTH-1:0] pop_wdata, pop_addr, pop_sdata, pop_ldata;

  // The first cycles after reset retire a spurious write to R0; hide it.
  assign reg_f      = RegWrite && !((WriteRegister == '0) && (since_q < 3'd4));
  assign capture    = !halt_q;
  assign want_push  = capture && (reg_f || MemRead || MemWrite);
  assign drop       = want_push && fifo_full;
  assign push_entry = {reg_f, MemRead, MemWrite, WriteRegister, WriteData,
                       MemAddress, MemDataIn, MemDataOut};
  assign {pop_flags, pop_wreg, pop_wdata, pop_addr, pop_sdata, pop_ldata} = pop_entry;
  assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty;

  trace_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (want_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (pop_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    stat_inc              = '0;
    stat_inc[STAT_CYCLES] = 1'b1;
    stat_inc[STAT_INST]   = Halt || reg_f || MemWrite;
    stat_inc[STAT_IREQ]   = icache_req;
    stat_inc[STAT_IHIT]   = icache_hit;
    stat_inc[STAT_DREQ]   = dcache_req;
    stat_inc[STAT_DHIT]   = dcache_hit;
    stat_inc[STAT_DROPS]  = drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      since_q    <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_STATS; i++) cnt_q[i] <= '0;
    end else begin
      if (since_q != 3'd7) since_q <= since_q + 3'd1;
      // The Halt cycle itself still counts; everything after is frozen.
      if (capture) begin
        for (int i = 0; i < NUM_STATS; i++)
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(stat_inc[i]);
        if (drop) overflow_q <= 1'b1;
        if (Halt) halt_q <= 1'b1;
      end
    end
  end

  always_comb begin
    stat_value = '0;
    case (stat_sel)
      STAT_CYCLES: stat_value = cnt_q[0];
      STAT_INST:   stat_value = cnt_q[1];
      STAT_IREQ:   stat_value = cnt_q[2];
      STAT_IHIT:   stat_value = cnt_q[3];
      STAT_DREQ:   stat_value = cnt_q[4];
      STAT_DHIT:   stat_value = cnt_q[5];
      STAT_DROPS:  stat_value = cnt_q[6];
      default:     stat_value = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    sel_mask  = 3'b000;
    rec_valid = 1'b0;
    rec_type  = REC_REG;
    rec_addr  = '0;
    rec_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_EMIT;
          flags_d = pop_flags;
        end else if (halt_q) begin
          state_d = S_HALTR;
        end
      end
      S_EMIT: begin
        rec_valid = 1'b1;
        if (flags_q[2]) begin
          rec_type = REC_REG;
          rec_addr = ARCH_WIDTH'(cur_wreg_q);
          rec_data = cur_wdata_q;
          sel_mask = 3'b100;
        end else if (flags_q[1]) begin
          rec_type = REC_LOAD;
          rec_addr = cur_addr_q;
          rec_data = cur_ldata_q;
          sel_mask = 3'b010;
        end else begin
          rec_type = REC_STORE;
          rec_addr = cur_addr_q;
          rec_data = cur_sdata_q;
          sel_mask = 3'b001;
        end
        if (rec_ready) begin
          flags_d = flags_q & ~sel_mask;
          if (flags_d == 3'b000) state_d = S_IDLE;
        end
      end
      S_HALTR: begin
        rec_valid = 1'b1;
        rec_type  = REC_HALT;
        if (rec_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      cur_wreg_q  <= '0;
      cur_wdata_q <= '0;
      cur_addr_q  <= '0;
      cur_sdata_q <= '0;
      cur_ldata_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (fifo_pop) begin
        cur_wreg_q  <= pop_wreg;
        cur_wdata_q <= pop_wdata;
        cur_addr_q  <= pop_addr;
        cur_sdata_q <= pop_sdata;
        cur_ldata_q <= pop_ldata;
      end
    end
  end

  assign overflow = overflow_q;
  assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire
